// File: rtl/uart_cmd_rcv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_cmd_rcv                                                    |
// | Function : 8N1 UART receiver assembling two bytes (high first) into a      |
// |            16-bit command with a cmd_rdy / clr_cmd_rdy handshake.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_cmd_rcv #(
    parameter int          BAUD_DIV = 5208,
    parameter logic [21:0] GAP_TO   = 22'h3FFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err,
    output logic        gap_err
);

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
    localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV - 1);

    typedef enum logic [0:0] {B_IDLE, B_SHIFT}     bit_state_t;
    typedef enum logic [0:0] {A_WAIT_HI, A_WAIT_LO} asm_state_t;

    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    bit_state_t      bstate_q, bstate_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            byte_rdy_q, byte_rdy_d;
    logic            frm_err_q, frm_err_d;
    asm_state_t      astate_q, astate_d;
    logic [7:0]      hi_q, hi_d;
    logic [21:0]     gap_q, gap_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            gap_err_q, gap_err_d;

    logic w_start;
    logic w_accept;

    assign w_start  = rx_s3_q & ~rx_s2_q;
    assign w_accept = (bstate_q == B_IDLE) && w_start;

    // Synchroniser flops preset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate_q   <= B_IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_rdy_q <= 1'b0;
            frm_err_q  <= 1'b0;
            astate_q   <= A_WAIT_HI;
            hi_q       <= '0;
            gap_q      <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            gap_err_q  <= 1'b0;
        end else begin
            bstate_q   <= bstate_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            byte_rdy_q <= byte_rdy_d;
            frm_err_q  <= frm_err_d;
            astate_q   <= astate_d;
            hi_q       <= hi_d;
            gap_q      <= gap_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            gap_err_q  <= gap_err_d;
        end
    end

    always_comb begin
        bstate_d   = bstate_q;
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        byte_rdy_d = 1'b0;
        frm_err_d  = 1'b0;
        case (bstate_q)
            B_IDLE: begin
                if (w_start) begin
                    bstate_d  = B_SHIFT;
                    baud_d    = BAUD_HALF;
                    bit_cnt_d = '0;
                end
            end
            B_SHIFT: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_FULL;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0) begin
                        if (rx_s2_q) begin
                            bstate_d = B_IDLE;
                        end
                    end else if (bit_cnt_q == 4'd9) begin
                        bstate_d   = B_IDLE;
                        byte_rdy_d = rx_s2_q;
                        frm_err_d  = ~rx_s2_q;
                    end else begin
                        shreg_d = {rx_s2_q, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    // The received byte stays in shreg_q while byte_rdy_q is high.
    always_comb begin
        logic done;
        done      = 1'b0;
        astate_d  = astate_q;
        hi_d      = hi_q;
        gap_d     = gap_q;
        cmd_d     = cmd_q;
        gap_err_d = 1'b0;
        case (astate_q)
            A_WAIT_HI: begin
                if (byte_rdy_q) begin
                    hi_d     = shreg_q;
                    gap_d    = '0;
                    astate_d = A_WAIT_LO;
                end
            end
            A_WAIT_LO: begin
                if (byte_rdy_q) begin
                    cmd_d    = {hi_q, shreg_q};
                    done     = 1'b1;
                    astate_d = A_WAIT_HI;
                end else if (frm_err_q) begin
                    astate_d = A_WAIT_HI;
                end else if (gap_q == GAP_TO) begin
                    gap_err_d = 1'b1;
                    astate_d  = A_WAIT_HI;
                end else if (bstate_q == B_IDLE) begin
                    gap_d = gap_q + 22'd1;
                end
            end
            default: astate_d = A_WAIT_HI;
        endcase

        cmd_rdy_d = cmd_rdy_q;
        if (done) begin
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (w_accept && (astate_q == A_WAIT_HI))) begin
            cmd_rdy_d = 1'b0;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = frm_err_q;
    assign gap_err = gap_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rcv.sv
`default_nettype none
// Directed + randomized bench for uart_cmd_rcv; a serial driver feeds frames and
// a small command/flag model supplies every expected value.
module tb_uart_cmd_rcv;

    localparam int          BAUD = 16;
    localparam logic [21:0] GAP  = 22'd2000;
    // Clocks from start-bit drive to cmd_rdy: 2 sync flops + edge flop, half a
    // bit to the start sample, nine bit periods to the stop sample, one more clock.
    localparam int          LAT  = 3 + BAUD / 2 + 1 + 9 * BAUD + 1;
    localparam int          STOP_IDX = LAT - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;
    logic        gap_err;

    int n_total = 0;
    int n_pass  = 0;
    int frm_cnt = 0;
    int gap_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_err) frm_cnt = frm_cnt + 1;
        if (gap_err) gap_cnt = gap_cnt + 1;
    end

    uart_cmd_rcv #(.BAUD_DIV(BAUD), .GAP_TO(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .frm_err     (frm_err),
        .gap_err     (gap_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rise/fall: clock index within the frame at which cmd_rdy rose/fell, -1 if never.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at,
                             output int rise, output int fall);
        logic [9:0] frame;
        logic       prev;
        frame = {stop, b, 1'b0};
        rise  = -1;
        fall  = -1;
        prev  = cmd_rdy;
        for (int k = 0; k < 10 * BAUD; k++) begin
            RX          = frame[k / BAUD];
            clr_cmd_rdy = (k == clr_at);
            @(posedge clk);
            #1;
            if (!prev && cmd_rdy && rise < 0) rise = k + 1;
            if (prev && !cmd_rdy && fall < 0) fall = k + 1;
            prev = cmd_rdy;
        end
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] c, input int gap, input int clr_at,
                            output int rise, output int fall_hi);
        int r_hi, f_lo;
        send_byte(c[15:8], 1'b1, -1, r_hi, fall_hi);
        if (gap > 0) idle(gap);
        send_byte(c[7:0], 1'b1, clr_at, rise, f_lo);
    endtask

    initial begin
        int rise, fall, f0, g0, gi, r, f;
        logic [15:0] v;
        logic        model_rdy;

        // Reset and idle
        rst_n = 1'b0;
        RX    = 1'b1;
        idle(3);
        check("reset_cmd", 32'(cmd), 32'h0);
        check("reset_rdy", 32'(cmd_rdy), 32'h0);
        rst_n = 1'b1;
        f0 = frm_cnt;
        g0 = gap_cnt;
        idle(200);
        check("idle_cmd", 32'(cmd), 32'h0);
        check("idle_rdy", 32'(cmd_rdy), 32'h0);
        check("idle_err_pulses", 32'((frm_cnt - f0) + (gap_cnt - g0)), 32'h0);

        // Single command and clear
        send_cmd(16'h4024, 0, -1, rise, fall);
        check("c4024_cmd", 32'(cmd), 32'h4024);
        check("c4024_rdy", 32'(cmd_rdy), 32'h1);
        check("c4024_latency", 32'(rise), 32'(LAT));
        idle(5);
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
        check("clr_rdy", 32'(cmd_rdy), 32'h0);
        check("clr_cmd_kept", 32'(cmd), 32'h4024);

        // Back-to-back commands, no clear
        send_cmd(16'h3001, 0, -1, rise, fall);
        check("c3001_cmd", 32'(cmd), 32'h3001);
        check("c3001_latency", 32'(rise), 32'(LAT));
        send_cmd(16'h2BF2, 0, -1, rise, fall);
        check("c2bf2_drop_at_start", 32'(fall), 32'h3);
        check("c2bf2_cmd", 32'(cmd), 32'h2BF2);
        check("c2bf2_rdy", 32'(cmd_rdy), 32'h1);
        check("c2bf2_latency", 32'(rise), 32'(LAT));

        // Gap timeout after a lone high byte
        g0 = gap_cnt;
        send_byte(8'h20, 1'b1, -1, r, f);
        gi = -1;
        for (int i = 1; i <= 2500; i++) begin
            idle(1);
            if (gap_err && gi < 0) gi = 10 * BAUD + i - STOP_IDX;
        end
        check("gap_timing", 32'((gi >= int'(GAP) - 4) && (gi <= int'(GAP) + 4)), 32'h1);
        check("gap_pulse_count", 32'(gap_cnt - g0), 32'h1);
        check("gap_rdy", 32'(cmd_rdy), 32'h0);
        send_cmd(16'h0000, 0, -1, rise, fall);
        check("c0000_cmd", 32'(cmd), 32'h0000);
        check("c0000_rdy", 32'(cmd_rdy), 32'h1);

        // Framing error on the high byte
        f0 = frm_cnt;
        g0 = gap_cnt;
        send_byte(8'h3F, 1'b0, -1, r, f);
        idle(5);
        check("frm_pulse_count", 32'(frm_cnt - f0), 32'h1);
        send_cmd(16'h3F02, 7, -1, rise, fall);
        check("c3f02_cmd", 32'(cmd), 32'h3F02);
        check("c3f02_rdy", 32'(cmd_rdy), 32'h1);
        check("frm_no_gap_err", 32'(gap_cnt - g0), 32'h0);

        // Short glitch: false start, yet it is a start edge in WAIT_HI
        f0 = frm_cnt;
        g0 = gap_cnt;
        RX = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(200);
        check("glitch_err_pulses", 32'((frm_cnt - f0) + (gap_cnt - g0)), 32'h0);
        check("glitch_cmd_kept", 32'(cmd), 32'h3F02);
        check("glitch_rdy_cleared", 32'(cmd_rdy), 32'h0);
        send_cmd(16'h1234, 0, -1, rise, fall);
        check("c1234_cmd", 32'(cmd), 32'h1234);

        // Reset in the middle of the low byte
        send_byte(8'h40, 1'b1, -1, r, f);
        RX = 1'b0;
        idle(50);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", 32'(cmd), 32'h0);
        check("midrst_rdy", 32'(cmd_rdy), 32'h0);
        RX = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(20);
        send_cmd(16'h4024, 0, -1, rise, fall);
        check("postrst_cmd", 32'(cmd), 32'h4024);
        check("postrst_latency", 32'(rise), 32'(LAT));

        // clr_cmd_rdy coincident with completion: set wins
        send_cmd(16'h5A5A, 0, STOP_IDX, rise, fall);
        check("coinc_cmd", 32'(cmd), 32'h5A5A);
        check("coinc_rdy", 32'(cmd_rdy), 32'h1);
        model_rdy = 1'b1;

        // Randomized commands against the command/flag model
        for (int n = 0; n < 6; n++) begin
            v = 16'($urandom);
            send_cmd(v, int'($urandom_range(0, 300)), -1, rise, fall);
            check("rnd_hi_start_drop", 32'(fall), model_rdy ? 32'h3 : 32'hFFFF_FFFF);
            check("rnd_cmd", 32'(cmd), 32'(v));
            check("rnd_latency", 32'(rise), 32'(LAT));
            model_rdy = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                idle(2);
                clr_cmd_rdy = 1'b1;
                idle(1);
                clr_cmd_rdy = 1'b0;
                model_rdy   = 1'b0;
            end
            idle(int'($urandom_range(1, 40)));
            check("rnd_rdy", 32'(cmd_rdy), 32'(model_rdy));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
